// File: rtl/regfile_mp_pkg.sv
// Shared defaults and types for the multi-port register file.
// No logic; constants and the write-port record only.
// No flow control; consumers are always-accept.
package regfile_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_ADDR  = 0;

  typedef struct packed {
    logic                  en;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/regfile_mp_rdport.sv
// One read port: register mux, zero-register forcing, optional write bypass (REGFILE_MP_BYPASS_EN).
// Latency: combinational.
// Backpressure: none.
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
  input  logic [DEPTH-1:0]              pend,
`ifdef REGFILE_MP_BYPASS_EN
  input  logic                          wr0_go,
  input  logic [ADDR_W-1:0]             wr0_addr,
  input  logic [DATA_W-1:0]             wr0_data,
  input  logic                          wr1_hit,
  input  logic [ADDR_W-1:0]             wr1_addr,
  input  logic [DATA_W-1:0]             wr1_data,
  input  logic                          iss_go,
  input  logic [ADDR_W-1:0]             iss_addr,
`endif
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_pending
);

  always_comb begin
    rd_data    = regs[rd_addr];
    rd_pending = pend[rd_addr];
`ifdef REGFILE_MP_BYPASS_EN
    // A write landing this edge retires the old producer; only a same-cycle issue keeps it pending.
    if (wr0_go && (wr0_addr == rd_addr)) begin
      rd_data    = wr0_data;
      rd_pending = iss_go && (iss_addr == rd_addr);
    end else if (wr1_hit && (wr1_addr == rd_addr)) begin
      rd_data    = wr1_data;
      rd_pending = iss_go && (iss_addr == rd_addr);
    end
`endif
    if (rd_addr == ADDR_W'(ZERO_ADDR)) begin
      rd_data    = '0;
      rd_pending = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Register file: 2 write ports, NUM_RD read ports, pending scoreboard; bypass under REGFILE_MP_BYPASS_EN.
// Latency: writes/issues commit at the edge; reads combinational; Wr_collision one cycle after.
// Backpressure: none; every request is accepted, Wr1 is dropped on a same-address collision.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic                       Wr0_en,
  input  logic [ADDR_W-1:0]          Wr0_addr,
  input  logic [DATA_W-1:0]          Wr0_data,
  input  logic                       Wr1_en,
  input  logic [ADDR_W-1:0]          Wr1_addr,
  input  logic [DATA_W-1:0]          Wr1_data,
  input  logic                       Iss_en,
  input  logic [ADDR_W-1:0]          Iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   Rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   Rd_data,
  output logic [NUM_RD-1:0]          Rd_pending,
  output logic                       Wr_collision
);

  localparam int DEPTH = 2**ADDR_W;

  logic                             armed;
  logic [DEPTH-1:0][DATA_W-1:0]     regs;
  logic [DEPTH-1:0]                 pend;
  logic [DEPTH-1:0]                 pend_nxt;
  logic                             same_addr;
  logic                             wr0_go;
  logic                             wr1_hit;
  logic                             wr1_go;
  logic                             iss_go;

  // armed stays low through the first edge after reset release so that edge is ignored.
  assign same_addr = (Wr0_addr == Wr1_addr);
  assign wr0_go    = armed && Wr0_en && (Wr0_addr != ADDR_W'(ZERO_ADDR));
  assign wr1_hit   = armed && Wr1_en && (Wr1_addr != ADDR_W'(ZERO_ADDR));
  assign wr1_go    = wr1_hit && !(wr0_go && same_addr);
  assign iss_go    = armed && Iss_en && (Iss_addr != ADDR_W'(ZERO_ADDR));

  always_comb begin
    pend_nxt = pend;
    if (wr0_go)  pend_nxt[Wr0_addr] = 1'b0;
    if (wr1_hit) pend_nxt[Wr1_addr] = 1'b0;
    if (iss_go)  pend_nxt[Iss_addr] = 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      armed        <= 1'b0;
      regs         <= '0;
      pend         <= '0;
      Wr_collision <= 1'b0;
    end else begin
      armed        <= 1'b1;
      Wr_collision <= wr0_go && wr1_hit && same_addr;
      pend         <= pend_nxt;
      if (wr0_go) regs[Wr0_addr] <= Wr0_data;
      if (wr1_go) regs[Wr1_addr] <= Wr1_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_rdport (
      .rd_addr    (Rd_addr[k*ADDR_W +: ADDR_W]),
      .regs       (regs),
      .pend       (pend),
`ifdef REGFILE_MP_BYPASS_EN
      .wr0_go     (wr0_go),
      .wr0_addr   (Wr0_addr),
      .wr0_data   (Wr0_data),
      .wr1_hit    (wr1_hit),
      .wr1_addr   (Wr1_addr),
      .wr1_data   (Wr1_data),
      .iss_go     (iss_go),
      .iss_addr   (Iss_addr),
`endif
      .rd_data    (Rd_data[k*DATA_W +: DATA_W]),
      .rd_pending (Rd_pending[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized + directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;

  logic               Clock = 1'b0;
  logic               Resetn;
  logic               Wr0_en, Wr1_en, Iss_en;
  logic [AW-1:0]      Wr0_addr, Wr1_addr, Iss_addr;
  logic [DW-1:0]      Wr0_data, Wr1_data;
  logic [NR*AW-1:0]   Rd_addr;
  logic [NR*DW-1:0]   Rd_data;
  logic [NR-1:0]      Rd_pending;
  logic               Wr_collision;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .Wr0_en       (Wr0_en),
    .Wr0_addr     (Wr0_addr),
    .Wr0_data     (Wr0_data),
    .Wr1_en       (Wr1_en),
    .Wr1_addr     (Wr1_addr),
    .Wr1_data     (Wr1_data),
    .Iss_en       (Iss_en),
    .Iss_addr     (Iss_addr),
    .Rd_addr      (Rd_addr),
    .Rd_data      (Rd_data),
    .Rd_pending   (Rd_pending),
    .Wr_collision (Wr_collision)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  bit            m_col;
  bit            m_armed;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_col   = 1'b0;
    m_armed = 1'b0;
  endtask

  // Wr1 is applied first so a same-address Wr0 overwrites it.
  task automatic model_edge();
    if (!Resetn) begin
      model_reset();
      return;
    end
    if (!m_armed) begin
      m_armed = 1'b1;
      m_col   = 1'b0;
      return;
    end
    m_col = Wr0_en && Wr1_en && (Wr0_addr == Wr1_addr) && (Wr0_addr != 0);
    if (Wr1_en && Wr1_addr != 0) begin
      m_mem[Wr1_addr]  = Wr1_data;
      m_pend[Wr1_addr] = 1'b0;
    end
    if (Wr0_en && Wr0_addr != 0) begin
      m_mem[Wr0_addr]  = Wr0_data;
      m_pend[Wr0_addr] = 1'b0;
    end
    if (Iss_en && Iss_addr != 0) m_pend[Iss_addr] = 1'b1;
  endtask

  function automatic bit byp_live();
`ifdef REGFILE_MP_BYPASS_EN
    return m_armed && (Resetn === 1'b1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (byp_live() && Wr0_en && Wr0_addr == a) return Wr0_data;
    if (byp_live() && Wr1_en && Wr1_addr == a) return Wr1_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_pend(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (byp_live() && ((Wr0_en && Wr0_addr == a) || (Wr1_en && Wr1_addr == a)))
      return Iss_en && (Iss_addr == a);
    return m_pend[a];
  endfunction

  function automatic logic [DW-1:0] rdp(input int k);
    return Rd_data[k*DW +: DW];
  endfunction

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    Rd_addr[0*AW +: AW] = AW'(a0);
    Rd_addr[1*AW +: AW] = AW'(a1);
    Rd_addr[2*AW +: AW] = AW'(a2);
    Rd_addr[3*AW +: AW] = AW'(a3);
  endtask

  task automatic idle();
    Wr0_en = 0; Wr0_addr = '0; Wr0_data = '0;
    Wr1_en = 0; Wr1_addr = '0; Wr1_data = '0;
    Iss_en = 0; Iss_addr = '0;
  endtask

  task automatic wr0(input int a, input logic [DW-1:0] d);
    Wr0_en = 1; Wr0_addr = AW'(a); Wr0_data = d;
  endtask

  task automatic wr1(input int a, input logic [DW-1:0] d);
    Wr1_en = 1; Wr1_addr = AW'(a); Wr1_data = d;
  endtask

  task automatic iss(input int a);
    Iss_en = 1; Iss_addr = AW'(a);
  endtask

  task automatic check_reads(input string tag);
    for (int k = 0; k < NR; k++) begin
      check($sformatf("%s_data%0d", tag, k), 64'(rdp(k)), 64'(exp_rd(Rd_addr[k*AW +: AW])));
      check($sformatf("%s_pend%0d", tag, k), 64'(Rd_pending[k]), 64'(exp_pend(Rd_addr[k*AW +: AW])));
    end
    check({tag, "_col"}, 64'(Wr_collision), 64'(m_col));
  endtask

  // Inputs are set at a falling edge; outputs are compared 1 ns later, then the edge is taken.
  task automatic cyc(input string tag);
    #1;
    check_reads(tag);
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
  endtask

  initial begin
    Resetn = 1'b0;
    idle();
    set_rd(5, 6, 0, 31);
    model_reset();
    repeat (2) @(negedge Clock);
    #1;
    check_reads("rst_state");
    Resetn = 1'b1;
    cyc("rel");

    // Reset mid-run, with writes held during and across reset release.
    wr0(5, 32'h1234); iss(6); cyc("r5_wr");
    idle(); cyc("r5_rd");
    check("r5_before_rst", 64'(rdp(0)), 64'h1234);
    check("r6_pend_before_rst", 64'(Rd_pending[1]), 64'h1);
    Resetn = 1'b0;
    model_reset();
    #1;
    check("r5_async_rst", 64'(rdp(0)), 64'h0);
    check("pend_async_rst", 64'(Rd_pending), 64'h0);
    wr0(5, 32'hDEAD); iss(5);
    cyc("in_rst");
    Resetn = 1'b1;
    cyc("rel_edge");
    idle(); cyc("after_rel");
    check("rel_write_ignored", 64'(rdp(0)), 64'h0);
    check("rel_iss_ignored", 64'(Rd_pending[0]), 64'h0);

    // Dual write to distinct registers.
    set_rd(3, 31, 3, 31);
    wr0(3, 32'hAAAA0000); wr1(31, 32'h00400008); cyc("dual");
    idle(); #1;
    check("dual_r3", 64'(rdp(0)), 64'hAAAA0000);
    check("dual_r31", 64'(rdp(1)), 64'h00400008);
    check("dual_nocol", 64'(Wr_collision), 64'h0);
    cyc("dual_rd");

    // Same-address collision: Wr0 wins, pulse lasts one cycle, pending cleared.
    set_rd(7, 7, 0, 0);
    iss(7); cyc("col_iss");
    idle(); wr0(7, 32'h11); wr1(7, 32'h22); cyc("col_wr");
    idle(); #1;
    check("col_r7", 64'(rdp(0)), 64'h11);
    check("col_pulse", 64'(Wr_collision), 64'h1);
    check("col_pend7", 64'(Rd_pending[0]), 64'h0);
    cyc("col_next");
    #1;
    check("col_pulse_end", 64'(Wr_collision), 64'h0);

    // Zero register ignores writes and issues.
    set_rd(0, 0, 0, 0);
    wr0(0, 32'hFFFFFFFF); iss(0); cyc("zero_wr");
    idle(); #1;
    check("zero_data", 64'(rdp(0)), 64'h0);
    check("zero_pend", 64'(Rd_pending), 64'h0);
    cyc("zero_rd");

    // Scoreboard lifecycle on R9.
    set_rd(9, 9, 9, 9);
    iss(9); cyc("sb_iss");
    idle(); #1;
    check("sb_pend_set", 64'(Rd_pending), 64'hF);
    cyc("sb_hold");
    wr0(9, 32'h55); iss(9); cyc("sb_wr_iss");
    idle(); #1;
    check("sb_r9", 64'(rdp(2)), 64'h55);
    check("sb_pend_stays", 64'(Rd_pending), 64'hF);
    cyc("sb_hold2");
    wr0(9, 32'h66); cyc("sb_wr");
    idle(); #1;
    check("sb_pend_clr", 64'(Rd_pending), 64'h0);
    cyc("sb_done");

    // Same-cycle read of a register being written.
    set_rd(4, 4, 4, 4);
    wr0(4, 32'h1); cyc("byp_pre");
    idle(); wr0(4, 32'hBEEF);
    #1;
    for (int k = 0; k < NR; k++) begin
`ifdef REGFILE_MP_BYPASS_EN
      check($sformatf("byp_r4_p%0d", k), 64'(rdp(k)), 64'hBEEF);
`else
      check($sformatf("byp_r4_p%0d", k), 64'(rdp(k)), 64'h1);
`endif
    end
    cyc("byp_wr");
    idle(); #1;
    check("byp_after", 64'(rdp(3)), 64'hBEEF);
    cyc("byp_done");

    // Random traffic; small address window to provoke collisions and port aliasing.
    for (int n = 0; n < 400; n++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? 31 : 7;
      Wr0_en   = $urandom_range(0, 1);
      Wr0_addr = AW'($urandom_range(0, lim));
      Wr0_data = $urandom;
      Wr1_en   = ($urandom_range(0, 2) == 0);
      Wr1_addr = AW'($urandom_range(0, lim));
      Wr1_data = $urandom;
      Iss_en   = ($urandom_range(0, 2) == 0);
      Iss_addr = AW'($urandom_range(0, lim));
      for (int k = 0; k < NR; k++) Rd_addr[k*AW +: AW] = AW'($urandom_range(0, lim));
      cyc("rnd");
    end

    idle(); cyc("end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
